two_phase_clock_monitor: RTL and testbench

Synchronous checker on the receiving side of the two-phase clock generator. Samples the generator outputs CLK1, CLK2 and O_S on the master clock and verifies the expected sequence: non-overlapping phases and an O_S toggle per phase pulse. Reports lock status, single-cycle error pulses and a saturating error count to the test/debug logic. One instance sits beside each two-phase generator.

---
 rtl/two_phase_clock_monitor_pkg.sv | 56 +++++
 rtl/two_phase_clock_monitor_phase_sampler.sv | 28 ++
 rtl/two_phase_clock_monitor.sv | 137 +++++++++++++
 tb/tb_two_phase_clock_monitor.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/two_phase_clock_monitor_pkg.sv
// Shared definitions for the two-phase clock monitor: FSM state codes,
// the sampled (CLK1,CLK2) patterns that make up one generator period,
// and small helpers describing the expected sequence.
package two_phase_clock_monitor_pkg;

  // Monitor FSM state codes; the numeric values are exported on STATE.
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4
  } monitorState_t;

  // Sampled {s1,s2} patterns.
  localparam logic [1:0] PAT_P1      = 2'b10;
  localparam logic [1:0] PAT_P2      = 2'b01;
  localparam logic [1:0] PAT_GAP     = 2'b00;
  localparam logic [1:0] PAT_OVERLAP = 2'b11;

  // Width of the error-free period counter; LOCK_PERIODS tops out at 15.
  localparam int PERIOD_CNT_W = 4;

  // Pattern the next sample must show when the FSM sits in state s.
  function automatic logic [1:0] expectedPattern(input monitorState_t s);
    logic [1:0] pat;
    case (s)
      P1:      pat = PAT_GAP;
      G1:      pat = PAT_P2;
      P2:      pat = PAT_GAP;
      G2:      pat = PAT_P1;
      default: pat = PAT_P1;
    endcase
    return pat;
  endfunction

  // State reached from s when the expected pattern (and O_S toggle) is seen.
  function automatic monitorState_t successorState(input monitorState_t s);
    monitorState_t nxt;
    case (s)
      HUNT:    nxt = P1;
      P1:      nxt = G1;
      G1:      nxt = P2;
      P2:      nxt = G2;
      G2:      nxt = P1;
      default: nxt = HUNT;
    endcase
    return nxt;
  endfunction

  // True when leaving s enters a phase pulse, where O_S must have toggled.
  function automatic logic entersCheckedPulse(input monitorState_t s);
    return (s == G1) || (s == G2);
  endfunction

endpackage

// File: rtl/two_phase_clock_monitor_phase_sampler.sv
// Input register stage of the two-phase clock monitor. CLK1, CLK2 and O_S
// are registered once on the master clock; everything downstream only ever
// looks at these samples, so no input reaches an output combinationally.
module phase_sampler (
  input  logic clock,
  input  logic resetN,
  input  logic clk1,
  input  logic clk2,
  input  logic oS,
  output logic s1,
  output logic s2,
  output logic so
);

  // Capture the three generator outputs every master clock edge.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      so <= 1'b0;
    end else begin
      s1 <= clk1;
      s2 <= clk2;
      so <= oS;
    end
  end

endmodule

// File: rtl/two_phase_clock_monitor.sv
// Two-phase clock monitor. Follows the sampled (CLK1,CLK2) sequence
// (1,0) -> (0,0) -> (0,1) -> (0,0), checks that O_S toggles at every phase
// pulse, declares lock after LOCK_PERIODS clean periods, and reports each
// violation as a one-cycle ERR pulse plus a saturating ERR_CNT.
module two_phase_clock_monitor
  import two_phase_clock_monitor_pkg::*;
#(
  parameter int LOCK_PERIODS = 4,
  parameter int ERR_W        = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLK1,
  input  logic             CLK2,
  input  logic             O_S,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             ERR,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       STATE
);

  localparam logic [PERIOD_CNT_W-1:0] LOCK_TARGET = PERIOD_CNT_W'(LOCK_PERIODS);
  localparam logic [ERR_W-1:0]        ERR_CNT_MAX = '1;
  localparam logic [ERR_W-1:0]        ERR_CNT_ONE = ERR_W'(1);

  logic s1;
  logic s2;
  logic so;
  logic [1:0] sample;

  monitorState_t            state;
  monitorState_t            nextState;
  logic                     lastOs;
  logic [PERIOD_CNT_W-1:0]  periodCnt;
  logic                     locked;
  logic                     err;
  logic [ERR_W-1:0]         errCnt;

  logic violation;
  logic captureOs;
  logic periodDone;
  logic osToggled;

  phase_sampler uSampler (
    .clock  (CLK),
    .resetN (RST_N),
    .clk1   (CLK1),
    .clk2   (CLK2),
    .oS     (O_S),
    .s1     (s1),
    .s2     (s2),
    .so     (so)
  );

  assign sample    = {s1, s2};
  assign osToggled = (so != lastOs);

  // Decode the registered sample against the current state: where to go
  // next, whether this is a violation, and whether a period just completed.
  // In HUNT the first phase-1 pulse is accepted without an O_S check since
  // there is no previous O_S value to compare against yet.
  always_comb begin
    nextState  = state;
    violation  = 1'b0;
    captureOs  = 1'b0;
    periodDone = 1'b0;
    if (state == HUNT) begin
      if (sample == PAT_OVERLAP) begin
        violation = 1'b1;
      end else if (sample == PAT_P1) begin
        nextState = P1;
        captureOs = 1'b1;
      end
    end else if ((sample != expectedPattern(state)) ||
                 (entersCheckedPulse(state) && !osToggled)) begin
      violation = 1'b1;
      nextState = HUNT;
    end else begin
      nextState  = successorState(state);
      captureOs  = entersCheckedPulse(state);
      periodDone = (state == G2);
    end
  end

  // Sequence FSM with its lock bookkeeping and registered error pulse.
  // Lock needs LOCK_PERIODS consecutive clean periods; any violation
  // drops back to HUNT and forgets all progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= HUNT;
      lastOs    <= 1'b0;
      periodCnt <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= nextState;
      err   <= violation;
      if (captureOs) begin
        lastOs <= so;
      end
      if (violation) begin
        periodCnt <= '0;
        locked    <= 1'b0;
      end else if (periodDone) begin
        if (periodCnt != LOCK_TARGET) begin
          periodCnt <= periodCnt + 1'b1;
        end
        if ((periodCnt + 1'b1) == LOCK_TARGET) begin
          locked <= 1'b1;
        end
      end
    end
  end

  // Saturating violation counter. A clear that coincides with a violation
  // leaves the count at one so that violation is not lost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      errCnt <= '0;
    end else if (violation) begin
      if (CLR_ERR) begin
        errCnt <= ERR_CNT_ONE;
      end else if (errCnt != ERR_CNT_MAX) begin
        errCnt <= errCnt + ERR_CNT_ONE;
      end
    end else if (CLR_ERR) begin
      errCnt <= '0;
    end
  end

  assign STATE   = state;
  assign LOCKED  = locked;
  assign ERR     = err;
  assign ERR_CNT = errCnt;

endmodule

// File: tb/tb_two_phase_clock_monitor.sv
// Bench for the two-phase clock monitor. A generator model drives both a
// default instance and an ERR_W=2 instance; a position-in-period reference
// model predicts all outputs edge by edge.
module tb_two_phase_clock_monitor;

  localparam int LP = 4;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       CLK1 = 1'b0;
  logic       CLK2 = 1'b0;
  logic       O_S = 1'b0;
  logic       CLR_ERR = 1'b0;
  logic       LOCKED;
  logic       ERR;
  logic [7:0] ERR_CNT;
  logic [2:0] STATE;
  logic       satLocked;
  logic       satErr;
  logic [1:0] satCnt;
  logic [2:0] satState;
  logic [19:0] actVec;

  int checks = 0;
  int failures = 0;

  // reference model: mPos = -1 while hunting, else 0..3 position in period
  int   mPos;
  int   mPeriods;
  int   mCnt8;
  int   mCnt2;
  logic mLastOs;
  logic mLocked;
  logic mErr;
  logic mS1;
  logic mS2;
  logic mSo;

  // generator model
  int   gPh;
  logic gOs;

  two_phase_clock_monitor #(.LOCK_PERIODS(LP), .ERR_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLK1(CLK1), .CLK2(CLK2), .O_S(O_S),
    .CLR_ERR(CLR_ERR), .LOCKED(LOCKED), .ERR(ERR), .ERR_CNT(ERR_CNT),
    .STATE(STATE)
  );

  two_phase_clock_monitor #(.LOCK_PERIODS(LP), .ERR_W(2)) dutSat (
    .CLK(CLK), .RST_N(RST_N), .CLK1(CLK1), .CLK2(CLK2), .O_S(O_S),
    .CLR_ERR(CLR_ERR), .LOCKED(satLocked), .ERR(satErr), .ERR_CNT(satCnt),
    .STATE(satState)
  );

  assign actVec = {STATE, LOCKED, ERR, ERR_CNT, satState, satLocked, satErr, satCnt};

  always #5 CLK = ~CLK;

  task automatic modelReset();
    mPos = -1; mPeriods = 0; mCnt8 = 0; mCnt2 = 0;
    mLastOs = 1'b0; mLocked = 1'b0; mErr = 1'b0;
    mS1 = 1'b0; mS2 = 1'b0; mSo = 1'b0;
  endtask

  // one master-clock edge of the reference: act on previous samples, then sample
  task automatic modelEdge(input logic c1, input logic c2, input logic os, input logic clr);
    logic       viol;
    logic [1:0] pat;
    logic [1:0] want;
    int         nxt;
    viol = 1'b0;
    pat = {mS1, mS2};
    if (mPos < 0) begin
      if (pat == 2'b11) viol = 1'b1;
      else if (pat == 2'b10) begin mPos = 0; mLastOs = mSo; end
    end else begin
      nxt = (mPos + 1) % 4;
      want = (nxt == 0) ? 2'b10 : (nxt == 2) ? 2'b01 : 2'b00;
      if (pat != want) viol = 1'b1;
      else if ((nxt == 0 || nxt == 2) && mSo == mLastOs) viol = 1'b1;
      if (!viol) begin
        mPos = nxt;
        if (nxt == 0 || nxt == 2) mLastOs = mSo;
        if (nxt == 0) begin
          if (mPeriods < LP) mPeriods++;
          if (mPeriods == LP) mLocked = 1'b1;
        end
      end
    end
    if (viol) begin
      mPos = -1; mPeriods = 0; mLocked = 1'b0;
      mCnt8 = clr ? 1 : ((mCnt8 < 255) ? mCnt8 + 1 : 255);
      mCnt2 = clr ? 1 : ((mCnt2 < 3) ? mCnt2 + 1 : 3);
    end else if (clr) begin
      mCnt8 = 0; mCnt2 = 0;
    end
    mErr = viol;
    mS1 = c1; mS2 = c2; mSo = os;
  endtask

  function automatic logic [19:0] expVec();
    logic [2:0] st;
    st = (mPos < 0) ? 3'd0 : 3'(mPos + 1);
    return {st, mLocked, mErr, 8'(mCnt8), st, mLocked, mErr, 2'(mCnt2)};
  endfunction

  task automatic step(input logic c1, input logic c2, input logic os, input logic clr);
    CLK1 = c1; CLK2 = c2; O_S = os; CLR_ERR = clr;
    @(posedge CLK);
    modelEdge(c1, c2, os, clr);
    #1;
  endtask

  // fault: 0 none, 1 force overlap, 2 drop CLK2 pulse, 3 hold O_S
  task automatic genStep(input int fault, input logic clr);
    logic c1;
    logic c2;
    c1 = (gPh == 0);
    c2 = (gPh == 2) && (fault != 2);
    if ((gPh == 0 || gPh == 2) && fault != 3) gOs = ~gOs;
    if (fault == 1) begin c1 = 1'b1; c2 = 1'b1; end
    gPh = (gPh + 1) % 4;
    step(c1, c2, gOs, clr);
  endtask

  task automatic doReset();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    CLK1 = 1'b0; CLK2 = 1'b0; O_S = 1'b0; CLR_ERR = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    modelReset();
    gPh = 0; gOs = 1'b0;
  endtask

  // reset then run the generator through edge 19 (lock edge)
  task automatic lockUp();
    doReset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (18) genStep(0, 1'b0);
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (actVec !== 20'h0) begin
      failures++;
      $display("[TB] FAIL reset_values actual=%h required=%h", actVec, 20'h0);
    end
  endtask

  task automatic test_lock();
    logic errSeen;
    errSeen = 1'b0;
    doReset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 2; e <= 24; e++) begin
      genStep(0, 1'b0);
      if (ERR) errSeen = 1'b1;
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL lock_model edge=%0d actual=%h required=%h", e, actVec, expVec());
      end
      if (e == 3) begin
        checks++;
        if (STATE !== 3'd1) begin
          failures++;
          $display("[TB] FAIL lock_p1_entry actual=%0d required=1", STATE);
        end
      end
      if (e == 18 || e == 19) begin
        checks++;
        if (LOCKED !== (e == 19)) begin
          failures++;
          $display("[TB] FAIL lock_latency edge=%0d actual=%b required=%b", e, LOCKED, e == 19);
        end
      end
    end
    checks++;
    if (errSeen || ERR_CNT !== 8'd0) begin
      failures++;
      $display("[TB] FAIL lock_no_error actual=%0d/%b required=0/0", ERR_CNT, errSeen);
    end
  endtask

  task automatic test_overlap();
    lockUp();
    genStep(1, 1'b0);  // edge 20
    checks++;
    if (ERR !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overlap_early actual=%b required=0", ERR);
    end
    genStep(0, 1'b0);  // edge 21
    checks++;
    if ({ERR, LOCKED, STATE, ERR_CNT} !== {1'b1, 1'b0, 3'd0, 8'd1}) begin
      failures++;
      $display("[TB] FAIL overlap_err actual=%h required=%h", {ERR, LOCKED, STATE, ERR_CNT}, {1'b1, 1'b0, 3'd0, 8'd1});
    end
    for (int e = 22; e <= 42; e++) begin
      genStep(0, 1'b0);
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL overlap_model edge=%0d actual=%h required=%h", e, actVec, expVec());
      end
      if (e == 38 || e == 39) begin
        checks++;
        if (LOCKED !== (e == 39)) begin
          failures++;
          $display("[TB] FAIL overlap_relock edge=%0d actual=%b required=%b", e, LOCKED, e == 39);
        end
      end
    end
  endtask

  task automatic test_os_stuck();
    lockUp();
    for (int e = 20; e <= 43; e++) begin
      genStep(3, 1'b0);
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL os_stuck_model edge=%0d actual=%h required=%h", e, actVec, expVec());
      end
      if (e == 21) begin
        checks++;
        if ({ERR, LOCKED, ERR_CNT} !== {1'b1, 1'b0, 8'd1}) begin
          failures++;
          $display("[TB] FAIL os_stuck_first actual=%h required=%h", {ERR, LOCKED, ERR_CNT}, {1'b1, 1'b0, 8'd1});
        end
      end
    end
  endtask

  task automatic test_saturate();
    doReset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL saturate_model i=%0d actual=%h required=%h", i, actVec, expVec());
      end
    end
    checks++;
    if (satCnt !== 2'd3 || ERR_CNT !== 8'd5) begin
      failures++;
      $display("[TB] FAIL saturate_count actual=%0d/%0d required=3/5", satCnt, ERR_CNT);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({ERR, satCnt, ERR_CNT} !== {1'b1, 2'd1, 8'd1}) begin
      failures++;
      $display("[TB] FAIL clr_with_error actual=%h required=%h", {ERR, satCnt, ERR_CNT}, {1'b1, 2'd1, 8'd1});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({satCnt, ERR_CNT} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL clr_alone actual=%0d/%0d required=0/0", satCnt, ERR_CNT);
    end
    CLR_ERR = 1'b0;
  endtask

  task automatic test_drop_clk2();
    lockUp();
    for (int e = 20; e <= 51; e++) begin
      genStep(2, 1'b0);
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL drop_clk2_model edge=%0d actual=%h required=%h", e, actVec, expVec());
      end
      if (e >= 21) begin
        checks++;
        if (LOCKED !== 1'b0) begin
          failures++;
          $display("[TB] FAIL drop_clk2_locked edge=%0d actual=%b required=0", e, LOCKED);
        end
      end
    end
    checks++;
    if (ERR_CNT < 8'd2) begin
      failures++;
      $display("[TB] FAIL drop_clk2_repeat actual=%0d required>=2", ERR_CNT);
    end
  endtask

  task automatic test_async_reset();
    lockUp();
    genStep(0, 1'b0);
    genStep(0, 1'b0);
    checks++;
    if (LOCKED !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_locked actual=%b required=1", LOCKED);
    end
    #2;
    RST_N = 1'b0;
    CLK1 = 1'b0; CLK2 = 1'b0; O_S = 1'b0;
    #1;
    checks++;
    if (actVec !== 20'h0) begin
      failures++;
      $display("[TB] FAIL async_reset actual=%h required=%h", actVec, 20'h0);
    end
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    modelReset();
    gPh = 0; gOs = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int e = 2; e <= 20; e++) begin
      genStep(0, 1'b0);
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL relock_model edge=%0d actual=%h required=%h", e, actVec, expVec());
      end
      if (e == 18 || e == 19) begin
        checks++;
        if (LOCKED !== (e == 19)) begin
          failures++;
          $display("[TB] FAIL relock_latency edge=%0d actual=%b required=%b", e, LOCKED, e == 19);
        end
      end
    end
  endtask

  task automatic test_random();
    int   fault;
    logic clr;
    doReset();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      fault = ($urandom_range(0, 19) < 17) ? 0 : int'($urandom_range(1, 3));
      clr = ($urandom_range(0, 15) == 0);
      genStep(fault, clr);
      checks++;
      if (actVec !== expVec()) begin
        failures++;
        $display("[TB] FAIL random_model i=%0d actual=%h required=%h", i, actVec, expVec());
      end
    end
    CLR_ERR = 1'b0;
  endtask

  initial begin
    modelReset();
    gPh = 0; gOs = 1'b0;
    test_reset();
    test_lock();
    test_overlap();
    test_os_stuck();
    test_saturate();
    test_drop_clk2();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
